// File: rtl/s6_gtp_rx_frame_sync_if.sv
// GTP receive word in, byte-realigned word plus lock/error status out.
// master drives the raw GTP side and observes results; slave is the frame sync block.
// No handshake: one word per rx_clk80 cycle, the receiver cannot stall the GTP.
interface s6_gtp_rx_frame_sync_if;
  logic        reset_done;
  logic [31:0] rx_data;
  logic [3:0]  rx_is_kchar;
  logic [3:0]  rx_disperr;
  logic [3:0]  rx_notintable;
  logic        err_cnt_clr;
  logic [31:0] data_out;
  logic [3:0]  kchar_out;
  logic        data_valid;
  logic        locked;
  logic [1:0]  comma_lane;
  logic        lock_lost;
  logic [15:0] err_cnt;

  modport master (
    output reset_done, rx_data, rx_is_kchar, rx_disperr, rx_notintable, err_cnt_clr,
    input  data_out, kchar_out, data_valid, locked, comma_lane, lock_lost, err_cnt
  );

  modport slave (
    input  reset_done, rx_data, rx_is_kchar, rx_disperr, rx_notintable, err_cnt_clr,
    output data_out, kchar_out, data_valid, locked, comma_lane, lock_lost, err_cnt
  );
endinterface

// File: rtl/s6_gtp_rx_frame_sync.sv
// Comma-based word alignment and lock tracking for a 4-byte GTP receive path.
// Latency: 2 rx_clk80 cycles from first byte of an aligned word to data_out, any lane.
// Backpressure: none; a new word is accepted and produced every cycle.
module s6_gtp_rx_frame_sync #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 4
) (
  input logic                   rx_clk80,
  input logic                   reset,
  s6_gtp_rx_frame_sync_if.slave bus
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t      state, state_next;
  logic [3:0]  good_cnt, good_next;
  logic [3:0]  bad_cnt, bad_next;
  logic [1:0]  comma_lane, lane_next;
  logic        lost_next;

  logic [3:0]  hit;
  logic [1:0]  hit_lane;
  logic        comma_evt, code_err, clean, bad;

  logic [31:0] d1, data_q, aligned;
  logic [3:0]  k1, kchar_q, k_aligned;
  logic        valid_q, lost_q;
  logic [15:0] err_q;
  logic [63:0] data_cat;
  logic [7:0]  k_cat;
  logic [5:0]  byte_shift;

  // Per-lane comma match; only a single matching lane counts as a comma event
  always_comb begin
    hit      = '0;
    hit_lane = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = bus.rx_is_kchar[i] && (bus.rx_data[8*i +: 8] == COMMA);
      if (hit[i]) hit_lane = 2'(i);
    end
    comma_evt = $onehot(hit);
    code_err  = |(bus.rx_disperr | bus.rx_notintable);
    clean     = comma_evt && !code_err;
    bad       = code_err || (comma_evt && (hit_lane != comma_lane));
  end

  // Next state, counters and captured lane; a comma elsewhere is only "bad" once a lane is held
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    lane_next  = comma_lane;
    lost_next  = 1'b0;
    if (!bus.reset_done) begin
      state_next = HUNT;
      good_next  = '0;
      bad_next   = '0;
      lost_next  = (state == LOCKED);
    end else begin
      case (state)
        HUNT: begin
          if (clean) begin
            lane_next  = hit_lane;
            good_next  = 4'd1;
            bad_next   = '0;
            state_next = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (bad) begin
            state_next = HUNT;
            good_next  = '0;
          end else if (clean) begin
            good_next = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) begin
              state_next = LOCKED;
              bad_next   = '0;
            end
          end
        end
        LOCKED: begin
          if (bad) begin
            if (bad_cnt + 4'd1 == LOSS_N) begin
              state_next = HUNT;
              good_next  = '0;
              bad_next   = '0;
              lost_next  = 1'b1;
            end else begin
              bad_next = bad_cnt + 4'd1;
            end
          end else if (clean) begin
            bad_next = '0;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Realign: bytes L..3 of the previous word followed by bytes 0..L-1 of the current word
  always_comb begin
    data_cat   = {bus.rx_data, d1};
    k_cat      = {bus.rx_is_kchar, k1};
    byte_shift = {comma_lane, 3'b000};
    aligned    = data_cat[byte_shift +: 32];
    k_aligned  = k_cat[{1'b0, comma_lane} +: 4];
  end

  // FSM state, stage-1 delay, output stage and error counter
  always_ff @(posedge rx_clk80) begin
    if (reset) begin
      state      <= HUNT;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      comma_lane <= '0;
      d1         <= '0;
      k1         <= '0;
      data_q     <= '0;
      kchar_q    <= '0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state      <= state_next;
      good_cnt   <= good_next;
      bad_cnt    <= bad_next;
      comma_lane <= lane_next;
      d1         <= bus.rx_data;
      k1         <= bus.rx_is_kchar;
      data_q     <= aligned;
      kchar_q    <= k_aligned;
      valid_q    <= (state == LOCKED);
      lost_q     <= lost_next;
      if (bus.err_cnt_clr) begin
        err_q <= '0;
      end else if ((state == LOCKED) && bus.reset_done && code_err && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.kchar_out  = kchar_q;
  assign bus.data_valid = valid_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.comma_lane = comma_lane;
  assign bus.lock_lost  = lost_q;
  assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_s6_gtp_rx_frame_sync.sv
// Randomized scoreboard bench for s6_gtp_rx_frame_sync against a byte-stream reference model.
// Driver pushes the expected post-edge outputs; monitor pops and compares on the falling edge.
// No backpressure exists on the DUT, so exactly one expectation is produced per cycle.
module tb_s6_gtp_rx_frame_sync;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         LOSS_COUNT = 4;

  logic rx_clk80 = 1'b0;
  logic reset    = 1'b1;

  s6_gtp_rx_frame_sync_if bus();

  s6_gtp_rx_frame_sync #(
    .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)
  ) dut (
    .rx_clk80(rx_clk80),
    .reset(reset),
    .bus(bus)
  );

  always #5 rx_clk80 = ~rx_clk80;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    logic        vld;
    logic        lck;
    logic        lost;
    logic [1:0]  lane;
    logic [15:0] err;
    bit          chk_data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: a sliding window over the received byte stream plus lock bookkeeping
  logic [7:0] m_bytes[$];
  logic       m_kq[$];
  bit         m_locked;
  int         m_streak, m_miss, m_lane, m_err;

  task automatic model_step(output exp_t e);
    int hits, hit_lane;
    bit cerr, clean, bad;
    e = '{default: 0};
    if (reset) begin
      m_locked = 0; m_streak = 0; m_miss = 0; m_lane = 0; m_err = 0;
      m_bytes = {}; m_kq = {};
      for (int b = 0; b < 4; b++) begin
        m_bytes.push_back(8'h00);
        m_kq.push_back(1'b0);
      end
      e.chk_data = 1'b1;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      m_bytes.push_back(bus.rx_data[8*b +: 8]);
      m_kq.push_back(bus.rx_is_kchar[b]);
    end
    while (m_bytes.size() > 8) begin
      void'(m_bytes.pop_front());
      void'(m_kq.pop_front());
    end
    for (int j = 0; j < 4; j++) begin
      e.data[8*j +: 8] = m_bytes[m_lane + j];
      e.k[j]           = m_kq[m_lane + j];
    end
    e.vld      = m_locked;
    e.chk_data = m_locked;

    hits = 0; hit_lane = 0;
    for (int b = 0; b < 4; b++)
      if (bus.rx_is_kchar[b] && bus.rx_data[8*b +: 8] == COMMA) begin
        hits++;
        hit_lane = b;
      end
    cerr  = (bus.rx_disperr | bus.rx_notintable) != 4'b0;
    clean = (hits == 1) && !cerr;
    bad   = cerr || ((hits == 1) && (hit_lane != m_lane));

    if (m_locked && bus.reset_done && cerr && m_err < 65535) m_err++;
    if (bus.err_cnt_clr) m_err = 0;

    if (!bus.reset_done) begin
      if (m_locked) e.lost = 1'b1;
      m_locked = 0; m_streak = 0; m_miss = 0;
    end else if (m_locked) begin
      if (bad) begin
        m_miss++;
        if (m_miss == LOSS_COUNT) begin
          m_locked = 0; m_miss = 0; m_streak = 0;
          e.lost = 1'b1;
        end
      end else if (clean) begin
        m_miss = 0;
      end
    end else if (m_streak == 0) begin
      if (clean) begin
        m_lane = hit_lane;
        m_streak = 1;
        if (LOCK_COUNT == 1) begin m_locked = 1; m_miss = 0; end
      end
    end else begin
      if (bad) m_streak = 0;
      else if (clean) begin
        m_streak++;
        if (m_streak == LOCK_COUNT) begin m_locked = 1; m_miss = 0; end
      end
    end
    e.lck  = m_locked;
    e.lane = 2'(m_lane);
    e.err  = 16'(m_err);
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                            input logic [3:0] ni, input logic rd, input logic clr);
    exp_t e;
    bus.rx_data       = d;
    bus.rx_is_kchar   = k;
    bus.rx_disperr    = de;
    bus.rx_notintable = ni;
    bus.reset_done    = rd;
    bus.err_cnt_clr   = clr;
    model_step(e);
    q.push_back(e);
    @(posedge rx_clk80);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) drive_word($urandom, 4'($urandom), 4'b0, 4'b0, 1'b1, 1'b0);
    reset = 1'b0;
  endtask

  // Comma every 4th word in the given lane, with optional faults at percent probabilities
  task automatic run_phase(input int lane, input int n, input int p_err, input int p_wrong,
                           input int p_dbl, input int p_rd, input int p_clr);
    for (int c = 0; c < n; c++) begin
      logic [31:0] d;
      logic [3:0]  k, de, ni;
      int          wl, ol;
      d = $urandom; k = '0; de = '0; ni = '0;
      if (c % 4 == 0) begin
        wl = lane;
        if ($urandom_range(99) < p_wrong) wl = (lane + $urandom_range(1, 3)) % 4;
        d[8*wl +: 8] = COMMA; k[wl] = 1'b1;
        if ($urandom_range(99) < p_dbl) begin
          ol = (wl + $urandom_range(1, 3)) % 4;
          d[8*ol +: 8] = COMMA; k[ol] = 1'b1;
        end
      end else if ($urandom_range(9) == 0) begin
        ol = $urandom_range(3);
        d[8*ol +: 8] = 8'h7C; k[ol] = 1'b1;
      end
      if ($urandom_range(99) < p_err) begin
        if ($urandom_range(1) == 1) de[$urandom_range(3)] = 1'b1;
        else ni[$urandom_range(3)] = 1'b1;
      end
      drive_word(d, k, de, ni, !($urandom_range(99) < p_rd), ($urandom_range(99) < p_clr));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every presented output cycle against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge rx_clk80);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("locked",     {31'b0, bus.locked},     {31'b0, e.lck});
        check("data_valid", {31'b0, bus.data_valid}, {31'b0, e.vld});
        check("lock_lost",  {31'b0, bus.lock_lost},  {31'b0, e.lost});
        check("comma_lane", {30'b0, bus.comma_lane}, {30'b0, e.lane});
        check("err_cnt",    {16'b0, bus.err_cnt},    {16'b0, e.err});
        if (e.chk_data) begin
          check("data_out",  bus.data_out,            e.data);
          check("kchar_out", {28'b0, bus.kchar_out},  {28'b0, e.k});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed lane scenarios followed by a long mixed random run
  initial begin
    bus.rx_data = '0; bus.rx_is_kchar = '0; bus.rx_disperr = '0;
    bus.rx_notintable = '0; bus.reset_done = 1'b1; bus.err_cnt_clr = 1'b0;
    do_reset(3);
    run_phase(0, 40, 0, 0, 0, 0, 0);          // clean lock on lane 0
    run_phase(1, 48, 0, 0, 0, 0, 0);          // lane-1 commas: lose lock, relock on lane 1
    run_phase(2, 40, 0, 0, 0, 0, 0);          // stream shifted by two bytes
    run_phase(2, 200, 10, 0, 0, 0, 5);        // code errors and counter clears
    drive_word($urandom, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);  // drop reset_done
    run_phase(3, 300, 5, 10, 5, 1, 3);        // mixed faults
    do_reset(2);
    run_phase(0, 6, 0, 0, 0, 0, 0);           // reach VERIFY
    do_reset(2);                              // reset mid-VERIFY
    run_phase(1, 60, 0, 0, 50, 0, 0);         // frequent double commas
    for (int p = 0; p < 20; p++)
      run_phase($urandom_range(3), 100, 6, 8, 8, 1, 3);
    @(posedge rx_clk80);
    @(negedge rx_clk80);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
